// File: rtl/diffusion_pkg.sv
// diffusion_pkg: shared state encodings and default widths for the diffusion scheduler
package diffusion_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RUN     = 2'd1;
  localparam state_t ST_ADVANCE = 2'd2;
  localparam state_t ST_DONE    = 2'd3;
  localparam int DEF_ADDR_WIDTH = 13;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_STEPS  = 7;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant of one shared port, held while the owner keeps requesting
module rr_arbiter
  import diffusion_pkg::*;
#(
  parameter int NUM_ENG = 4,
  localparam int PW = $clog2(NUM_ENG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_ENG-1:0] req,
  input  logic               hold_en,
  output logic [NUM_ENG-1:0] gnt,
  output logic [PW-1:0]      rr_ptr
);
  logic [NUM_ENG-1:0] gnt_q, gnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      idx;
  logic               found;
  // hold the owner, release to idle for one cycle, else search from the pointer
  always_comb begin
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    if (!hold_en) gnt_d = '0;
    else if (|gnt_q) begin
      if (!(|(gnt_q & req))) begin
        gnt_d = '0;
        for (int i = 0; i < NUM_ENG; i++)
          if (gnt_q[i]) ptr_d = (i == NUM_ENG - 1) ? '0 : PW'(i + 1);
      end
    end else
      for (int k = 0; k < NUM_ENG; k++) begin
        idx = PW'((int'(ptr_q) + k) % NUM_ENG);
        if (!found && req[idx]) begin
          found      = 1'b1;
          gnt_d[idx] = 1'b1;
        end
      end
  end
  // grant and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q <= '0;
      ptr_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end
  assign gnt    = gnt_q;
  assign rr_ptr = ptr_q;
endmodule

// File: rtl/diffusion_scheduler.sv
// diffusion_scheduler: step sequencer and shared score-BRAM arbiter for diffusion engines
module diffusion_scheduler
  import diffusion_pkg::*;
#(
  parameter int NUM_ENG    = 4,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_STEPS  = DEF_MAX_STEPS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_ENG-1:0]            eng_req,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr,
  input  logic [NUM_ENG-1:0]            eng_we,
  input  logic [NUM_ENG*DATA_WIDTH-1:0] eng_wdata,
  input  logic [NUM_ENG-1:0]            eng_finished,
  output logic [NUM_ENG-1:0]            eng_rdy,
  output logic [NUM_ENG-1:0]            eng_conflict,
  output logic [DATA_WIDTH-1:0]         l_step,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic                          bram_we,
  output logic [DATA_WIDTH-1:0]         bram_wdata,
  output logic                          busy,
  output logic                          done
);
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] l_step_q, l_step_d;
  logic [NUM_ENG-1:0]    fin_lat_q, fin_lat_d;
  logic [NUM_ENG-1:0]    gnt;
  logic [$clog2(NUM_ENG)-1:0] rr_ptr;

  rr_arbiter #(.NUM_ENG(NUM_ENG)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (eng_req),
    .hold_en (state_q == ST_RUN),
    .gnt     (gnt),
    .rr_ptr  (rr_ptr)
  );

  // step sequencing; a step only ends once every engine finished and the port is idle
  always_comb begin
    state_d   = state_q;
    l_step_d  = l_step_q;
    fin_lat_d = fin_lat_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) begin
        state_d   = ST_RUN;
        l_step_d  = '0;
        fin_lat_d = '0;
      end
      ST_RUN: begin
        fin_lat_d = fin_lat_q | eng_finished;
        if (&fin_lat_q && !(|gnt)) state_d = ST_ADVANCE;
      end
      default: begin
        fin_lat_d = '0;
        if (l_step_q + 1'b1 == DATA_WIDTH'(MAX_STEPS)) state_d = ST_DONE;
        else begin
          state_d  = ST_RUN;
          l_step_d = l_step_q + 1'b1;
        end
      end
    endcase
  end

  // FSM, step counter and finished latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      l_step_q  <= '0;
      fin_lat_q <= '0;
    end else begin
      state_q   <= state_d;
      l_step_q  <= l_step_d;
      fin_lat_q <= fin_lat_d;
    end
  end

  // shared port follows the granted engine; no grant means a silent port
  always_comb begin
    bram_addr  = '0;
    bram_we    = 1'b0;
    bram_wdata = '0;
    for (int i = 0; i < NUM_ENG; i++)
      if (gnt[i]) begin
        bram_addr  = eng_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        bram_we    = eng_we[i];
        bram_wdata = eng_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end

  assign eng_rdy      = {NUM_ENG{state_q == ST_RUN}};
  assign eng_conflict = eng_req & ~gnt;
  assign l_step       = l_step_q;
  assign busy         = (state_q == ST_RUN) || (state_q == ST_ADVANCE);
  assign done         = (state_q == ST_DONE);
endmodule
